// File: rtl/blinker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blinker_pkg
//  Description : Shared types and 50 MHz default constants for the turn-signal
//                blinker sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package blinker_pkg;

    // Lighting mode; the encoding is also the value presented on the mode port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } blink_mode_t;

    // Defaults for a 50 MHz system clock
    localparam int c_HALF_PERIOD_50M = 16777216;  // ~0.34 s per half-period
    localparam int c_TAP_CYCLES_50M  = 25000000;  // ~0.5 s lane-change tap
    localparam int c_CNT_W           = 25;
    localparam int c_TAP_FLASHES     = 3;
    localparam int c_TAP_W           = 25;        // tap-length counter width

    // Saturating increment used for the flash counter
    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blinker_sequencer_flash_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : flash_timebase
//  Description : Half-period counter and ON/OFF phase for the blinker. A
//                synchronous restart starts a fresh ON half; dropping run
//                parks the timebase at count 0, phase OFF. Exposes the wrap
//                strobe, the OFF->ON strobe and the next phase value.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_timebase #(
    parameter int HALF_PERIOD = 16777216,
    parameter int CNT_W       = 25
) (
    input  logic clk,
    input  logic nReset,
    input  logic i_run,
    input  logic i_restart,
    output logic o_phaseOn,
    output logic o_phaseOnNext,
    output logic o_wrap,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] c_LAST_COUNT = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] r_halfCnt;
    logic [CNT_W-1:0] w_halfCntNext;
    logic             r_phaseOn;
    logic             w_phaseOnNext;
    logic             w_wrap;

    // Counter is held at 0 whenever idle, so a wrap can only occur while active
    assign w_wrap = (r_halfCnt == c_LAST_COUNT);

    // Next counter/phase: restart beats idle, idle beats normal counting
    always_comb begin
        w_halfCntNext = r_halfCnt + 1'b1;
        w_phaseOnNext = r_phaseOn;
        if (i_restart) begin
            w_halfCntNext = '0;
            w_phaseOnNext = 1'b1;
        end else if (!i_run) begin
            w_halfCntNext = '0;
            w_phaseOnNext = 1'b0;
        end else if (w_wrap) begin
            w_halfCntNext = '0;
            w_phaseOnNext = ~r_phaseOn;
        end
    end

    // Timebase registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_halfCnt <= '0;
            r_phaseOn <= 1'b0;
        end else begin
            r_halfCnt <= w_halfCntNext;
            r_phaseOn <= w_phaseOnNext;
        end
    end

    assign o_phaseOn     = r_phaseOn;
    assign o_phaseOnNext = w_phaseOnNext;
    assign o_wrap        = w_wrap;
    assign o_rise        = w_wrap & ~r_phaseOn;

endmodule
`default_nettype wire

// File: rtl/blinker_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : blinker_sequencer
//  Description : Arbitrates debounced left/right/hazard requests into one
//                lighting mode, runs a single phase-aligned flash timebase and
//                drives both lamp outputs. Enforces a minimum ON half on exit.
//                Optional macro LANE_CHANGE_EN adds the lane-change tap: a
//                short left/right request yields TAP_FLASHES full flashes.
//  Revision    : 1.0 - initial release
// ============================================================================
module blinker_sequencer
    import blinker_pkg::*;
#(
    parameter int HALF_PERIOD = c_HALF_PERIOD_50M,
    parameter int CNT_W       = c_CNT_W,
    parameter int TAP_CYCLES  = c_TAP_CYCLES_50M,
    parameter int TAP_FLASHES = c_TAP_FLASHES
) (
    input  logic       c50M,
    input  logic       nReset,
    input  logic       leftBlink,
    input  logic       rightBlink,
    input  logic       hazardBlink,
    output logic       leftBlinkerOut,
    output logic       rightBlinkerOut,
    output logic [1:0] mode,
    output logic [7:0] flashCount
);

    localparam logic [7:0] c_TAP_FLASH_N = 8'(TAP_FLASHES);

    blink_mode_t r_mode;
    blink_mode_t w_nextMode;
    blink_mode_t w_target;
    logic [7:0]  r_flashCount;
    logic [7:0]  w_nextFlash;
    logic        r_leftOut;
    logic        r_rightOut;
    logic        w_nextLeft;
    logic        w_nextRight;
    logic        w_restart;
    logic        w_run;
    logic        w_phaseOn;
    logic        w_phaseOnNext;
    logic        w_wrap;
    logic        w_rise;
    logic        w_tapHold;

    flash_timebase #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_timebase (
        .clk           (c50M),
        .nReset        (nReset),
        .i_run         (w_run),
        .i_restart     (w_restart),
        .o_phaseOn     (w_phaseOn),
        .o_phaseOnNext (w_phaseOnNext),
        .o_wrap        (w_wrap),
        .o_rise        (w_rise)
    );

    // Request decode: hazard wins; simultaneous left+right keeps the current mode
    always_comb begin
        w_target = IDLE;
        if (hazardBlink)
            w_target = HAZARD;
        else if (leftBlink && rightBlink)
            w_target = r_mode;
        else if (leftBlink)
            w_target = LEFT;
        else if (rightBlink)
            w_target = RIGHT;
    end

    // Next-state logic: entry/restart, minimum-ON exit, tap extension
    always_comb begin
        w_nextMode  = r_mode;
        w_restart   = 1'b0;
        w_nextFlash = w_rise ? satInc8(r_flashCount) : r_flashCount;
        if (r_mode == IDLE) begin
            w_nextFlash = 8'd0;
            if (w_target != IDLE) begin
                w_nextMode  = w_target;
                w_restart   = 1'b1;
                w_nextFlash = 8'd1;
            end
        end else if (w_target == IDLE) begin
            if (w_tapHold) begin
                // Tap runs whole flashes until the last counted ON half ends
                if (w_phaseOn && w_wrap && (r_flashCount >= c_TAP_FLASH_N))
                    w_nextMode = IDLE;
            end else if (!w_phaseOn || w_wrap) begin
                // OFF half: leave now; ON half: leave only as it completes
                w_nextMode = IDLE;
            end
            if (w_nextMode == IDLE)
                w_nextFlash = 8'd0;
        end else if (w_target != r_mode) begin
            w_nextMode  = w_target;
            w_restart   = 1'b1;
            w_nextFlash = 8'd1;
        end
    end

    assign w_run = (w_nextMode != IDLE);

    // Lamp drive computed from next-state values so the outputs are glitch-free
    assign w_nextLeft  = w_phaseOnNext & ((w_nextMode == LEFT)  | (w_nextMode == HAZARD));
    assign w_nextRight = w_phaseOnNext & ((w_nextMode == RIGHT) | (w_nextMode == HAZARD));

    // State and output registers; reset kills the lamps immediately
    always_ff @(posedge c50M or negedge nReset) begin
        if (!nReset) begin
            r_mode       <= IDLE;
            r_flashCount <= 8'd0;
            r_leftOut    <= 1'b0;
            r_rightOut   <= 1'b0;
        end else begin
            r_mode       <= w_nextMode;
            r_flashCount <= w_nextFlash;
            r_leftOut    <= w_nextLeft;
            r_rightOut   <= w_nextRight;
        end
    end

`ifdef LANE_CHANGE_EN
    localparam logic [c_TAP_W-1:0] c_TAP_LIMIT = c_TAP_W'(TAP_CYCLES);

    logic [c_TAP_W-1:0] r_tapLen;
    logic [c_TAP_W-1:0] w_nextTapLen;
    logic               r_tapEligible;
    logic               w_nextTapEligible;
    logic               r_tapArmed;
    logic               w_nextTapArmed;

    // A drop counts as a tap if the request was held fewer than TAP_CYCLES cycles
    assign w_tapHold = r_tapArmed | (r_tapEligible & (r_tapLen < c_TAP_LIMIT));

    // Tap tracking: measure request length after IDLE entry, arm on early drop
    always_comb begin
        w_nextTapLen      = r_tapLen;
        w_nextTapEligible = r_tapEligible;
        w_nextTapArmed    = r_tapArmed;
        if (r_mode == IDLE) begin
            w_nextTapArmed    = 1'b0;
            w_nextTapEligible = (w_target == LEFT) || (w_target == RIGHT);
            w_nextTapLen      = {{(c_TAP_W-1){1'b0}}, 1'b1};
        end else if (w_target == IDLE) begin
            w_nextTapArmed    = w_tapHold;
            w_nextTapEligible = 1'b0;
        end else if (w_target != r_mode || r_tapArmed) begin
            // Any fresh request aborts the tap and normal rules resume
            w_nextTapArmed    = 1'b0;
            w_nextTapEligible = 1'b0;
        end else if (r_tapEligible && (r_tapLen != {c_TAP_W{1'b1}})) begin
            w_nextTapLen = r_tapLen + 1'b1;
        end
        if (w_nextMode == IDLE) begin
            w_nextTapArmed    = 1'b0;
            w_nextTapEligible = 1'b0;
        end
    end

    // Tap state registers
    always_ff @(posedge c50M or negedge nReset) begin
        if (!nReset) begin
            r_tapLen      <= '0;
            r_tapEligible <= 1'b0;
            r_tapArmed    <= 1'b0;
        end else begin
            r_tapLen      <= w_nextTapLen;
            r_tapEligible <= w_nextTapEligible;
            r_tapArmed    <= w_nextTapArmed;
        end
    end
`else
    // Without the tap feature the minimum-ON rule alone governs exit
    logic w_unusedTapCfg;
    assign w_unusedTapCfg = (TAP_CYCLES > 0);
    assign w_tapHold      = 1'b0;
`endif

    assign leftBlinkerOut  = r_leftOut;
    assign rightBlinkerOut = r_rightOut;
    assign mode            = r_mode;
    assign flashCount      = r_flashCount;

endmodule
`default_nettype wire
